// File: rtl/pistorm16_pkg.sv
// Shared types and constants for the pistorm16 bus logic.
// Holds the 3-bit arbiter state encoding and the default grant timeout.
package pistorm16_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_REQUEST   = 3'd1,
        ARB_WAIT_FREE = 3'd2,
        ARB_OWN       = 3'd3,
        ARB_RELEASE   = 3'd4
    } arb_state_t;

    localparam int unsigned ARB_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/bus_arbiter_input_sync.sv
// STAGES-deep flip-flop synchronizer for one asynchronous bus line.
// Resets to 1, the idle level of the active-low Amiga bus signals.
module input_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/bus_arbiter.sv
// Amiga bus mastership arbiter, stepped on each 7 MHz falling-edge strobe.
// Define BUS_ARB_TIMEOUT_EN to abandon requests not granted in TIMEOUT_CYCLES.
module bus_arbiter
    import pistorm16_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic MC_CLK_FALLING,
    input  logic REQ,
    input  logic CYCLE_BUSY,
    input  logic nBG_IN,
    input  logic nAS_IN,
    input  logic nDTACK,
    input  logic nBGACK_IN,
    input  logic nRESET_IN,
    output logic DRIVE_BR,
    output logic DRIVE_BGACK,
    output logic MASTER,
    output logic TIMEOUT
);

    arb_state_t state_q;
    arb_state_t state_d;

    logic nbg_s;
    logic nas_s;
    logic ndtack_s;
    logic nbgack_s;
    logic nreset_s;
    logic bus_free;
    logic tmo_hit;
    logic br_d;
    logic own_d;

    input_sync #(.STAGES(SYNC_STAGES)) u_sync_bg (
        .clk(SYSCLK), .rst(RESET), .d(nBG_IN), .q(nbg_s)
    );
    input_sync #(.STAGES(SYNC_STAGES)) u_sync_as (
        .clk(SYSCLK), .rst(RESET), .d(nAS_IN), .q(nas_s)
    );
    input_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
        .clk(SYSCLK), .rst(RESET), .d(nDTACK), .q(ndtack_s)
    );
    input_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
        .clk(SYSCLK), .rst(RESET), .d(nBGACK_IN), .q(nbgack_s)
    );
    input_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
        .clk(SYSCLK), .rst(RESET), .d(nRESET_IN), .q(nreset_s)
    );

    assign bus_free = nas_s && ndtack_s && nbgack_s;

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_q <= ARB_IDLE;
        end else if (MC_CLK_FALLING) begin
            state_q <= state_d;
        end
    end

    // A sticky timeout blocks re-arming until REQ is dropped.
    always_comb begin
        state_d = state_q;
        if (!nreset_s) begin
            state_d = ARB_IDLE;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (REQ && !TIMEOUT) state_d = ARB_REQUEST;
                end
                ARB_REQUEST: begin
                    if (!REQ)         state_d = ARB_IDLE;
                    else if (tmo_hit) state_d = ARB_IDLE;
                    else if (!nbg_s)  state_d = ARB_WAIT_FREE;
                end
                ARB_WAIT_FREE: begin
                    if (tmo_hit)       state_d = ARB_IDLE;
                    else if (bus_free) state_d = ARB_OWN;
                end
                ARB_OWN: begin
                    if (!REQ && !CYCLE_BUSY) state_d = ARB_RELEASE;
                end
                ARB_RELEASE: state_d = ARB_IDLE;
                default:     state_d = ARB_IDLE;
            endcase
        end
    end

    // BR is held through the first strobe of ownership, then dropped.
    always_comb begin
        br_d  = (state_d == ARB_REQUEST) || (state_d == ARB_WAIT_FREE) ||
                (state_d == ARB_OWN && state_q == ARB_WAIT_FREE);
        own_d = (state_d == ARB_OWN);
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            DRIVE_BR    <= 1'b0;
            DRIVE_BGACK <= 1'b0;
            MASTER      <= 1'b0;
        end else if (MC_CLK_FALLING) begin
            DRIVE_BR    <= br_d;
            DRIVE_BGACK <= own_d;
            MASTER      <= own_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        tmo_flag;
    logic        waiting;

    assign waiting = (state_q == ARB_REQUEST) || (state_q == ARB_WAIT_FREE);
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (MC_CLK_FALLING) begin
            if (state_d == ARB_REQUEST && state_q != ARB_REQUEST) begin
                tmo_cnt <= '0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (!nreset_s || !REQ) begin
                tmo_flag <= 1'b0;
            end else if (tmo_hit) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    assign TIMEOUT = tmo_flag;
`else
    assign tmo_hit = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with an event-level reference model.
// Inputs change only just after a strobe, so they are settled by the next one.
module tb_bus_arbiter;

    localparam int TMO = 16;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic SYSCLK         = 1'b0;
    logic RESET          = 1'b1;
    logic MC_CLK_FALLING = 1'b0;
    logic REQ            = 1'b0;
    logic CYCLE_BUSY     = 1'b0;
    logic nBG_IN         = 1'b1;
    logic nAS_IN         = 1'b1;
    logic nDTACK         = 1'b1;
    logic nBGACK_IN      = 1'b1;
    logic nRESET_IN      = 1'b1;
    logic DRIVE_BR;
    logic DRIVE_BGACK;
    logic MASTER;
    logic TIMEOUT;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int unsigned cyc = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .MC_CLK_FALLING(MC_CLK_FALLING),
        .REQ(REQ), .CYCLE_BUSY(CYCLE_BUSY), .nBG_IN(nBG_IN),
        .nAS_IN(nAS_IN), .nDTACK(nDTACK), .nBGACK_IN(nBGACK_IN),
        .nRESET_IN(nRESET_IN), .DRIVE_BR(DRIVE_BR),
        .DRIVE_BGACK(DRIVE_BGACK), .MASTER(MASTER), .TIMEOUT(TIMEOUT)
    );

    always #5 SYSCLK = ~SYSCLK;

    // One strobe every fourth SYSCLK cycle.
    always @(negedge SYSCLK) begin
        cyc++;
        MC_CLK_FALLING = (cyc % 4 == 0);
    end

    // Model: asking for the bus, granted, strobes owned (-1 = not), releasing.
    bit m_ask = 0, m_gnt = 0, m_rel = 0, m_tmo = 0;
    int m_own = -1, m_wait = 0;

    always @(posedge SYSCLK) begin : model
        bit a, g, rl, t, hit, free;
        int o, w;
        a = m_ask; g = m_gnt; rl = m_rel; t = m_tmo; o = m_own; w = m_wait;
        hit = 1'b0;
        free = nAS_IN && nDTACK && nBGACK_IN;
        if (RESET) begin
            a = 0; g = 0; rl = 0; t = 0; o = -1; w = 0;
        end else if (MC_CLK_FALLING) begin
            if (!nRESET_IN) begin
                a = 0; g = 0; rl = 0; t = 0; o = -1;
            end else if (rl) begin
                rl = 0;
            end else if (o >= 0) begin
                if (!REQ && !CYCLE_BUSY) begin
                    o = -1; rl = 1;
                end else if (o < 1000) begin
                    o = o + 1;
                end
            end else if (a) begin
                w = w + 1;
                hit = TMO_ON && (w == TMO);
                if (!g && !REQ) a = 0;
                else if (hit) begin a = 0; g = 0; end
                else if (!g && !nBG_IN) g = 1;
                else if (g && free) begin a = 0; g = 0; o = 0; end
            end else if (REQ && !t) begin
                a = 1; w = 0;
            end
            if (!REQ || !nRESET_IN) t = 0;
            else if (hit) t = 1;
        end
        m_ask <= a; m_gnt <= g; m_rel <= rl; m_tmo <= t;
        m_own <= o; m_wait <= w;
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge SYSCLK) begin
        if (chk_en) begin
            check("model_br", DRIVE_BR, m_ask || (m_own == 0));
            check("model_bgack", DRIVE_BGACK, m_own >= 0);
            check("model_master", MASTER, m_own >= 0);
            check("model_timeout", TIMEOUT, m_tmo);
        end
    end

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge SYSCLK); while (MC_CLK_FALLING !== 1'b1);
        end
        @(negedge SYSCLK);
    endtask

    task automatic check_all_low(input string name);
        check({name, "_br"}, DRIVE_BR, 1'b0);
        check({name, "_bgack"}, DRIVE_BGACK, 1'b0);
        check({name, "_master"}, MASTER, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge SYSCLK);
        chk_en = 1'b1;
        check_all_low("reset");
        check("reset_tmo", TIMEOUT, 1'b0);
        RESET = 1'b0;
        strobes(2);

        // Normal acquisition: grant three strobes after the request.
        REQ = 1'b1;
        strobes(1);
        check("acq_br_s1", DRIVE_BR, 1'b1);
        check("acq_bgack_s1", DRIVE_BGACK, 1'b0);
        strobes(2);
        nBG_IN = 1'b0;
        strobes(1);
        check("acq_bgack_s4", DRIVE_BGACK, 1'b0);
        strobes(1);
        check("acq_bgack_own", DRIVE_BGACK, 1'b1);
        check("acq_master_own", MASTER, 1'b1);
        check("acq_br_own", DRIVE_BR, 1'b1);
        strobes(1);
        check("acq_br_drop", DRIVE_BR, 1'b0);
        check("acq_master_held", MASTER, 1'b1);
        REQ = 1'b0;
        nBG_IN = 1'b1;
        strobes(1);
        check_all_low("release");
        strobes(1);
        check_all_low("idle_after_rel");

        // Bus busy after the grant: wait for AS to go high.
        REQ = 1'b1;
        strobes(1);
        nBG_IN = 1'b0;
        nAS_IN = 1'b0;
        strobes(1);
        for (int i = 0; i < 5; i++) begin
            strobes(1);
            check("busy_bgack_low", DRIVE_BGACK, 1'b0);
        end
        nAS_IN = 1'b1;
        strobes(1);
        check("busy_bgack_own", DRIVE_BGACK, 1'b1);
        strobes(1);

        // A running cycle holds ownership after REQ drops.
        CYCLE_BUSY = 1'b1;
        REQ = 1'b0;
        nBG_IN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            strobes(1);
            check("hold_master", MASTER, 1'b1);
        end
        CYCLE_BUSY = 1'b0;
        strobes(1);
        check_all_low("hold_release");
        strobes(1);

        // Late grant after withdrawal is ignored.
        REQ = 1'b1;
        strobes(1);
        check("late_br_req", DRIVE_BR, 1'b1);
        REQ = 1'b0;
        strobes(1);
        check("late_br_wd", DRIVE_BR, 1'b0);
        nBG_IN = 1'b0;
        strobes(3);
        check_all_low("late_grant");
        nBG_IN = 1'b1;
        strobes(1);

        // Amiga bus reset while owning, and reset beating a request.
        REQ = 1'b1;
        nBG_IN = 1'b0;
        strobes(3);
        check("brst_master_own", MASTER, 1'b1);
        nRESET_IN = 1'b0;
        strobes(1);
        check_all_low("brst_own");
        strobes(1);
        check_all_low("brst_req");
        nRESET_IN = 1'b1;
        REQ = 1'b0;
        nBG_IN = 1'b1;
        strobes(2);

        // System reset in WAIT_FREE acts on the next SYSCLK edge.
        REQ = 1'b1;
        nBG_IN = 1'b0;
        nAS_IN = 1'b0;
        strobes(2);
        check("sys_br_wait", DRIVE_BR, 1'b1);
        RESET = 1'b1;
        @(posedge SYSCLK);
        @(negedge SYSCLK);
        check_all_low("sysrst");
        RESET = 1'b0;
        REQ = 1'b0;
        nBG_IN = 1'b1;
        nAS_IN = 1'b1;
        strobes(2);

        // Request never granted.
        REQ = 1'b1;
        strobes(1);
        check("ng_br_s1", DRIVE_BR, 1'b1);
        strobes(TMO - 1);
        check("ng_br_before", DRIVE_BR, 1'b1);
        check("ng_tmo_before", TIMEOUT, 1'b0);
        strobes(1);
`ifdef BUS_ARB_TIMEOUT_EN
        check("ng_br_expired", DRIVE_BR, 1'b0);
        check("ng_tmo_set", TIMEOUT, 1'b1);
        strobes(2);
        check("ng_tmo_sticky", TIMEOUT, 1'b1);
        check("ng_br_no_rearm", DRIVE_BR, 1'b0);
`else
        check("ng_br_waiting", DRIVE_BR, 1'b1);
        check("ng_tmo_tied", TIMEOUT, 1'b0);
        strobes(4);
        check("ng_br_still", DRIVE_BR, 1'b1);
`endif
        REQ = 1'b0;
        strobes(1);
        check("ng_tmo_clear", TIMEOUT, 1'b0);
        check("ng_br_idle", DRIVE_BR, 1'b0);
        strobes(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
